// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster sequencer.
// A prescaler divides the system clock down to the pixel rate. Paired x/y
// counters walk the raster, and horizontal and vertical phase FSMs track
// active / front porch / sync / back porch. Every output is registered and
// reflects the x/y values held in that same cycle.
// Optional feature: define VGA_FRAME_CNT_EN to add the frame_cnt[7:0] output,
// which counts frame_start strobes.
// Each porch and sync width is assumed to be at least one.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DIV      = 4,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_FRONT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] X_SYNC     = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] X_BACK     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_FRONT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] Y_SYNC     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] Y_BACK     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

  logic [PW-1:0]    presc_reg, presc_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] x_reg, x_next;
  logic [CNT_W-1:0] y_reg, y_next;
  logic             line_reg, line_next;
  logic             frame_reg, frame_next;
  logic             hsync_reg, vsync_reg, video_reg;
  h_state_t         h_state_reg, h_state_next;
  v_state_t         v_state_reg, v_state_next;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       frame_cnt_reg;
`endif

  // Prescaler: the tick is registered, so it appears in the cycle after the count reaches DIV-1.
  always_comb begin
    presc_next = '0;
    tick_next  = 1'b0;
    if (en) begin
      tick_next  = (presc_reg == PRESC_LAST);
      presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
    end
  end

  // Raster counters: step on each pixel tick, wrap at the totals, and return to the origin when disabled.
  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    line_next  = 1'b0;
    frame_next = 1'b0;
    if (!en) begin
      x_next = '0;
      y_next = '0;
    end else if (tick_reg) begin
      if (x_reg == X_LAST) begin
        x_next    = '0;
        line_next = 1'b1;
        if (y_reg == Y_LAST) begin
          y_next     = '0;
          frame_next = 1'b1;
        end else begin
          y_next = y_reg + 1'b1;
        end
      end else begin
        x_next = x_reg + 1'b1;
      end
    end
  end

  // Phase FSMs: counters move by one or jump to zero, so exact boundary compares are enough.
  always_comb begin
    h_state_next = h_state_reg;
    v_state_next = v_state_reg;
    if (x_next == '0) begin
      h_state_next = H_ACT;
    end else begin
      case (h_state_reg)
        H_ACT:   if (x_next == X_FRONT) h_state_next = H_FRONT;
        H_FRONT: if (x_next == X_SYNC)  h_state_next = H_SYNCP;
        H_SYNCP: if (x_next == X_BACK)  h_state_next = H_BACK;
        default: h_state_next = h_state_reg;
      endcase
    end
    if (y_next == '0) begin
      v_state_next = V_ACT;
    end else begin
      case (v_state_reg)
        V_ACT:   if (y_next == Y_FRONT) v_state_next = V_FRONT;
        V_FRONT: if (y_next == Y_SYNC)  v_state_next = V_SYNCP;
        V_SYNCP: if (y_next == Y_BACK)  v_state_next = V_BACK;
        default: v_state_next = v_state_reg;
      endcase
    end
  end

  // State and registered outputs; all of them are decoded from the next-cycle counter values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg     <= '0;
      tick_reg      <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      line_reg      <= 1'b0;
      frame_reg     <= 1'b0;
      h_state_reg   <= H_ACT;
      v_state_reg   <= V_ACT;
      hsync_reg     <= 1'b1;
      vsync_reg     <= 1'b1;
      video_reg     <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_reg <= '0;
`endif
    end else begin
      presc_reg   <= presc_next;
      tick_reg    <= tick_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      line_reg    <= line_next;
      frame_reg   <= frame_next;
      h_state_reg <= h_state_next;
      v_state_reg <= v_state_next;
      hsync_reg   <= (h_state_next != H_SYNCP);
      vsync_reg   <= (v_state_next != V_SYNCP);
      video_reg   <= en && (h_state_next == H_ACT) && (v_state_next == V_ACT);
`ifdef VGA_FRAME_CNT_EN
      if (!en)
        frame_cnt_reg <= '0;
      else if (frame_next)
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
`endif
    end
  end

  assign pixel_tick  = tick_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign line_end    = line_reg;
  assign frame_start = frame_reg;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized bench for vga_timing_ctrl.
// Two instances share one stimulus: a small raster with DIV=3 and the same
// raster with DIV=1. The reference model works from "enabled clock count" k,
// the number of consecutive enabled edges since the last reset or en=0. From
// that count it derives the pixel position and every expected output with
// plain arithmetic.
// Optional feature: with VGA_FRAME_CNT_EN defined, frame_cnt is connected and checked.
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 6;
  localparam int DIV_A = 3;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  logic a_tick, a_hs, a_vs, a_vo, a_le, a_fs;
  logic b_tick, b_hs, b_vs, b_vo, b_le, b_fs;
  logic [CW-1:0] a_x, a_y, b_x, b_y;
  logic [7:0] a_fc, b_fc;

  int total = 0;
  int bad = 0;
  int k = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .DIV(DIV_A), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en),
    .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .x(a_x), .y(a_y), .line_end(a_le), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .DIV(DIV_B), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en),
    .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .x(b_x), .y(b_y), .line_end(b_le), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign a_fc = 8'd0;
  assign b_fc = 8'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Ticks land on enabled edges k = DIV, 2*DIV, ...; each tick is consumed on the following edge.
  task automatic check_dut(input string name, input int div,
                           input logic tick, input logic hs, input logic vs, input logic vo,
                           input logic [CW-1:0] gx, input logic [CW-1:0] gy,
                           input logic le, input logic fs, input logic [7:0] fc);
    int p, ex, ey;
    logic step, e_tick;
    p      = (k == 0) ? 0 : (k - 1) / div;
    ex     = p % HT;
    ey     = (p / HT) % VT;
    e_tick = (k > 0) && (k % div == 0);
    step   = (k >= 2) && ((k - 1) % div == 0);
    check({name, ".pixel_tick"}, tick, e_tick);
    check({name, ".x"}, gx, ex);
    check({name, ".y"}, gy, ey);
    check({name, ".hsync"}, hs, !(ex >= HA + HF && ex < HA + HF + HS));
    check({name, ".vsync"}, vs, !(ey >= VA + VF && ey < VA + VF + VS));
    check({name, ".video_on"}, vo, (k > 0) && ex < HA && ey < VA);
    check({name, ".line_end"}, le, step && ex == 0);
    check({name, ".frame_start"}, fs, step && ex == 0 && ey == 0);
`ifdef VGA_FRAME_CNT_EN
    check({name, ".frame_cnt"}, fc, (p / (HT * VT)) % 256);
`endif
  endtask

  task automatic check_both();
    check_dut("a", DIV_A, a_tick, a_hs, a_vs, a_vo, a_x, a_y, a_le, a_fs, a_fc);
    check_dut("b", DIV_B, b_tick, b_hs, b_vs, b_vo, b_x, b_y, b_le, b_fs, b_fc);
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge, compare 1ns later.
  task automatic step(input logic r, input logic e);
    @(negedge clk);
    reset = r;
    en = e;
    @(posedge clk);
    if (!reset || !en) k = 0;
    else k++;
    #1;
    check_both();
  endtask

  initial begin
    logic hit;
    int p;
    // reset held with en high
    repeat (3) step(1'b0, 1'b1);
    // continuous run covering several full frames on both instances
    repeat (1300) step(1'b1, 1'b1);
    // randomized enable drops and occasional reset pulses
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 149) != 0));
    end
    // restart from idle, then run until instance a is inside its hsync pulse
    step(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(1'b1, 1'b1);
      p = (k - 1) / DIV_A;
      hit = ((p % HT) >= HA + HF + 1) && ((p % HT) < HA + HF + HS);
    end
    check("wait_hsync_region", hit, 1'b1);
    check("a.hsync_before_reset", a_hs, 1'b0);
    // asynchronous reset between edges takes effect without a clock
    @(negedge clk);
    #2;
    reset = 1'b0;
    k = 0;
    #1;
    check_both();
    step(1'b0, 1'b1);
    repeat (400) step(1'b1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
